// File: rtl/pwm_level_decoder_if.sv
// PWM line and decoded-level outputs of the PWM level decoder.
// master drives the line and observes results; slave is the decoder side.
interface pwm_level_decoder_if #(
  parameter int unsigned LVL_W = 4
);
  logic             pwm_i;
  logic [LVL_W-1:0] level_o;
  logic             level_valid_o;
  logic             locked_o;
  logic             dir_o;
  logic             turn_o;
  logic             frame_err_o;

  modport master (
    output pwm_i,
    input  level_o, level_valid_o, locked_o, dir_o, turn_o, frame_err_o
  );

  modport slave (
    input  pwm_i,
    output level_o, level_valid_o, locked_o, dir_o, turn_o, frame_err_o
  );
endinterface

// File: rtl/pwm_level_decoder.sv
// Aligns to the 16-slot PWM frame on pwm_i, recovers the 4-bit brightness,
// tracks breathing direction and flags reversals and framing faults.
module pwm_level_decoder (
  input  logic                  clk_div_i,
  input  logic                  rst_i,
  pwm_level_decoder_if.slave    bus
);
  localparam int unsigned LVL_W     = 4;
  localparam int unsigned FRAME_LEN = 16;
  localparam int unsigned CNT_W     = LVL_W + 1;
  localparam logic [LVL_W-1:0] POS_LAST = LVL_W'(FRAME_LEN - 1);

  typedef enum logic {HUNT, LOCKED} state_e;

  state_e           state_q, state_d;
  logic             p1_q, p2_q;
  logic [LVL_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [LVL_W-1:0] prev_lvl_q, prev_lvl_d;
  logic             have_prev_q, have_prev_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             dir_q, dir_d;
  logic             turn_q, turn_d;
  logic             err_q, err_d;

  logic             rise;
  logic [CNT_W-1:0] total;
  logic [LVL_W-1:0] new_lvl;

  assign rise  = p1_q & ~p2_q;
  assign total = hcnt_q + CNT_W'(p1_q);

  always_ff @(posedge clk_div_i or posedge rst_i) begin
    if (rst_i) begin
      p1_q        <= 1'b0;
      p2_q        <= 1'b0;
      state_q     <= HUNT;
      pos_q       <= '0;
      hcnt_q      <= '0;
      prev_lvl_q  <= '0;
      have_prev_q <= 1'b0;
      level_q     <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      dir_q       <= 1'b0;
      turn_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      p1_q        <= bus.pwm_i;
      p2_q        <= p1_q;
      state_q     <= state_d;
      pos_q       <= pos_d;
      hcnt_q      <= hcnt_d;
      prev_lvl_q  <= prev_lvl_d;
      have_prev_q <= have_prev_d;
      level_q     <= level_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      dir_q       <= dir_d;
      turn_q      <= turn_d;
      err_q       <= err_d;
    end
  end

  // Frame alignment, level decode and direction tracking.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    hcnt_d      = hcnt_q;
    prev_lvl_d  = prev_lvl_q;
    have_prev_d = have_prev_q;
    level_d     = level_q;
    dir_d       = dir_q;
    valid_d     = 1'b0;
    turn_d      = 1'b0;
    err_d       = 1'b0;
    new_lvl     = LVL_W'(total - CNT_W'(1));

    unique case (state_q)
      HUNT: begin
        if (rise) begin
          state_d = LOCKED;
          pos_d   = LVL_W'(1);
          hcnt_d  = CNT_W'(1);
        end
      end
      LOCKED: begin
        if (rise && (pos_q != '0)) begin
          // Misplaced edge: drop the partial frame and realign here.
          err_d  = 1'b1;
          pos_d  = LVL_W'(1);
          hcnt_d = CNT_W'(1);
        end else if (pos_q == POS_LAST) begin
          pos_d  = '0;
          hcnt_d = '0;
          if (total == '0) begin
            err_d       = 1'b1;
            state_d     = HUNT;
            have_prev_d = 1'b0;
          end else begin
            level_d     = new_lvl;
            valid_d     = 1'b1;
            prev_lvl_d  = new_lvl;
            have_prev_d = 1'b1;
            if (have_prev_q) begin
              if (new_lvl > prev_lvl_q)      dir_d = 1'b1;
              else if (new_lvl < prev_lvl_q) dir_d = 1'b0;
              turn_d = (dir_d != dir_q);
            end
          end
        end else begin
          pos_d  = pos_q + LVL_W'(1);
          hcnt_d = hcnt_q + CNT_W'(p1_q);
        end
      end
      default: state_d = HUNT;
    endcase

    locked_d = (state_d == LOCKED);
  end

  assign bus.level_o       = level_q;
  assign bus.level_valid_o = valid_q;
  assign bus.locked_o      = locked_q;
  assign bus.dir_o         = dir_q;
  assign bus.turn_o        = turn_q;
  assign bus.frame_err_o   = err_q;
endmodule
